pseudo_spi_recv: RTL
====================

PSEUDO_SPI_RECV -- requirements
Module: pseudo_spi_recv

Interface
REQ-001 CLK  input  1  single system clock; all state on rising edge.
REQ-002 RST  input  1  reset, asynchronous, active-high.
REQ-003 BGN  input  1  level enable; rising level starts a receive, low aborts.
REQ-004 ADDR_BGN  input  9  SRAM address of first received byte, sampled at start.
REQ-005 DATA_LEN  input  8  number of bytes to receive, sampled at start.
REQ-006 SCLK1  input  1  phase-1 serial clock from transmitter; accepted, not used for sampling.
REQ-007 SCLK2  input  1  phase-2 serial clock; SPI_SI sampled on its rising edge.
REQ-008 LAT  input  1  byte-boundary strobe; rising edge commits the shifted byte.
REQ-009 SPI_SI  input  1  serial data, MSB first.
REQ-010 CEN  output  1  SRAM chip enable, active-low.
REQ-011 WEN  output  1  SRAM write enable, active-low.
REQ-012 A  output  9  SRAM address.
REQ-013 D  output  8  SRAM write data.
REQ-014 RX_IS_DONE  output  1  high when DATA_LEN bytes are written; held until BGN low.
REQ-015 RX_ERR  output  1  sticky framing error flag.

Function
REQ-016 SCLK2, LAT and SPI_SI SHALL be registered into CLK. An edge SHALL be detected as registered value high and previous registered value low.
REQ-017 States SHALL be IDLE, SHIFT, WRITE and DONE. Reset state SHALL be IDLE.
REQ-018 IDLE -> SHIFT SHALL occur on the first cycle BGN=1. On that cycle ADDR_BGN and DATA_LEN are latched and the bit count, byte count and RX_ERR are cleared.
REQ-019 If DATA_LEN=0 at start, IDLE -> DONE SHALL occur directly, with no SRAM access.
REQ-020 In SHIFT, each SCLK2 rise with bit count <8 SHALL shift in the registered SPI_SI at the LSB (shift register left-shifts) and increment the bit count.
REQ-021 An SCLK2 rise with bit count =8 SHALL set RX_ERR and leave the shift register unchanged.
REQ-022 LAT rise in SHIFT with bit count =8 SHALL enter WRITE. The bit count SHALL clear.
REQ-023 LAT rise with bit count !=8 SHALL set RX_ERR, discard the partial byte, clear the bit count and stay in SHIFT.
REQ-024 WRITE SHALL last exactly one cycle with CEN=0, WEN=0, A=latched base + byte count (mod 512, wraps 511->0) and D=the shift register.
REQ-025 After WRITE the byte count SHALL increment. The next state SHALL be DONE if the count equals DATA_LEN, otherwise SHIFT.
REQ-026 Outside WRITE, CEN and WEN SHALL be 1. A and D SHALL hold their last values.
REQ-027 Latency SHALL be 3 CLK cycles from LAT input rise to the WRITE cycle: register, edge detect, WRITE.
REQ-028 In DONE, RX_IS_DONE SHALL be 1 and further SCLK2/LAT edges SHALL be ignored. BGN=0 SHALL return to IDLE and clear RX_IS_DONE.
REQ-029 BGN=0 in SHIFT or WRITE SHALL abort to IDLE next cycle. A WRITE cycle already in progress completes; no later writes occur. RX_ERR SHALL be retained.
REQ-030 SCLK2 and LAT rising on the same cycle SHALL be handled as the shift first, then the LAT check against the updated bit count.

Reset
REQ-031 RST=1 SHALL force IDLE asynchronously, including mid-operation, with CEN=1, WEN=1, A=0, D=0, RX_IS_DONE=0 and RX_ERR=0. Shift register, counters and input registers SHALL be 0.

Configuration
REQ-032 With PSEUDO_SPI_RECV_SYNC_EN defined, SCLK2, LAT and SPI_SI SHALL pass through an additional 2-flop synchronizer before the registers of REQ-016. Latency per REQ-027 then becomes 5 cycles; function is otherwise identical.
REQ-033 Without PSEUDO_SPI_RECV_SYNC_EN, inputs SHALL be treated as CLK-synchronous, with the single register stage and 3-cycle latency.

Verification
REQ-034 ADDR_BGN=16, DATA_LEN=2, serial bytes 0xA5 and 0x3C, each followed by a LAT pulse -> two single-cycle writes, A=16 D=0xA5 then A=17 D=0x3C. RX_IS_DONE=1, RX_ERR=0.
REQ-035 ADDR_BGN=511, DATA_LEN=2, bytes 0x01 and 0x02 -> writes at A=511 then A=0.
REQ-036 LAT after 5 bits, then a full byte 0xFF -> RX_ERR=1, partial byte discarded, one write of 0xFF, done after the next valid byte when DATA_LEN=2.
REQ-037 DATA_LEN=0 -> RX_IS_DONE=1 two cycles after BGN rise, CEN stays 1 throughout.
REQ-038 BGN dropped after 4 bits of byte 2 (DATA_LEN=3), then RST pulse mid-shift -> only byte 1 written, outputs return to reset values, RX_IS_DONE=0.
REQ-039 Latency check: LAT input rise -> CEN=0 exactly 3 cycles later, or 5 cycles with PSEUDO_SPI_RECV_SYNC_EN.

Source files
------------

// File: rtl/pseudo_spi_recv.sv
// Serial-to-SRAM byte receiver: shifts SPI_SI on SCLK2 rises and writes one byte per LAT rise.
// Define PSEUDO_SPI_RECV_SYNC_EN to add a 2-flop synchronizer on SCLK2, LAT and SPI_SI.
`timescale 1ns/1ps
module pseudo_spi_recv (
  input  logic       CLK,
  input  logic       RST,
  input  logic       BGN,
  input  logic [8:0] ADDR_BGN,
  input  logic [7:0] DATA_LEN,
  input  logic       SCLK1,
  input  logic       SCLK2,
  input  logic       LAT,
  input  logic       SPI_SI,
  output logic       CEN,
  output logic       WEN,
  output logic [8:0] A,
  output logic [7:0] D,
  output logic       RX_IS_DONE,
  output logic       RX_ERR
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  // SCLK1 is part of the transmitter interface but carries no timing we rely on.
  logic unused_sclk1;
  assign unused_sclk1 = SCLK1;

  // Bundle order: {SCLK2, LAT, SPI_SI}
  logic [2:0] raw_in;

`ifdef PSEUDO_SPI_RECV_SYNC_EN
  logic [2:0] sync1_reg;
  logic [2:0] sync2_reg;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= {SCLK2, LAT, SPI_SI};
      sync2_reg <= sync1_reg;
    end
  end

  assign raw_in = sync2_reg;
`else
  assign raw_in = {SCLK2, LAT, SPI_SI};
`endif

  logic [2:0] in_reg;
  logic [1:0] prev_reg;
  logic       sclk2_rise_reg;
  logic       lat_rise_reg;
  logic       si_reg;
  logic       sclk2_edge;
  logic       lat_edge;

  assign sclk2_edge = in_reg[2] & ~prev_reg[1];
  assign lat_edge   = in_reg[1] & ~prev_reg[0];

  // Edge flags are registered together with the data bit so they stay aligned.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      in_reg         <= '0;
      prev_reg       <= '0;
      sclk2_rise_reg <= 1'b0;
      lat_rise_reg   <= 1'b0;
      si_reg         <= 1'b0;
    end else begin
      in_reg         <= raw_in;
      prev_reg       <= in_reg[2:1];
      sclk2_rise_reg <= sclk2_edge;
      lat_rise_reg   <= lat_edge;
      si_reg         <= in_reg[0];
    end
  end

  logic [1:0] state_reg, state_next;
  logic [8:0] base_reg, base_next;
  logic [7:0] len_reg, len_next;
  logic [3:0] bit_cnt_reg, bit_cnt_next;
  logic [7:0] byte_cnt_reg, byte_cnt_next;
  logic [7:0] sr_reg, sr_next;
  logic       err_reg, err_next;
  logic [8:0] a_reg, a_next;
  logic [7:0] d_reg, d_next;

  always_comb begin
    state_next    = state_reg;
    base_next     = base_reg;
    len_next      = len_reg;
    bit_cnt_next  = bit_cnt_reg;
    byte_cnt_next = byte_cnt_reg;
    sr_next       = sr_reg;
    err_next      = err_reg;
    a_next        = a_reg;
    d_next        = d_reg;

    case (state_reg)
      IDLE: begin
        if (BGN) begin
          base_next     = ADDR_BGN;
          len_next      = DATA_LEN;
          bit_cnt_next  = 4'd0;
          byte_cnt_next = 8'd0;
          sr_next       = 8'd0;
          err_next      = 1'b0;
          state_next    = (DATA_LEN == 8'd0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        if (!BGN) begin
          state_next = IDLE;
        end else begin
          if (sclk2_rise_reg) begin
            if (bit_cnt_reg < 4'd8) begin
              sr_next      = {sr_reg[6:0], si_reg};
              bit_cnt_next = bit_cnt_reg + 4'd1;
            end else begin
              err_next = 1'b1;
            end
          end
          // LAT is judged against the count after any same-cycle shift.
          if (lat_rise_reg) begin
            if (bit_cnt_next == 4'd8) begin
              state_next = WRITE;
              a_next     = base_reg + {1'b0, byte_cnt_reg};
              d_next     = sr_next;
            end else begin
              err_next = 1'b1;
              sr_next  = 8'd0;
            end
            bit_cnt_next = 4'd0;
          end
        end
      end
      WRITE: begin
        byte_cnt_next = byte_cnt_reg + 8'd1;
        if (!BGN) begin
          state_next = IDLE;
        end else if (byte_cnt_next == len_reg) begin
          state_next = DONE;
        end else begin
          state_next = SHIFT;
        end
      end
      default: begin
        if (!BGN) begin
          state_next = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg    <= IDLE;
      base_reg     <= '0;
      len_reg      <= '0;
      bit_cnt_reg  <= '0;
      byte_cnt_reg <= '0;
      sr_reg       <= '0;
      err_reg      <= 1'b0;
      a_reg        <= '0;
      d_reg        <= '0;
    end else begin
      state_reg    <= state_next;
      base_reg     <= base_next;
      len_reg      <= len_next;
      bit_cnt_reg  <= bit_cnt_next;
      byte_cnt_reg <= byte_cnt_next;
      sr_reg       <= sr_next;
      err_reg      <= err_next;
      a_reg        <= a_next;
      d_reg        <= d_next;
    end
  end

  assign CEN        = (state_reg != WRITE);
  assign WEN        = (state_reg != WRITE);
  assign A          = a_reg;
  assign D          = d_reg;
  assign RX_IS_DONE = (state_reg == DONE);
  assign RX_ERR     = err_reg;

endmodule
